// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Sequential signed multiply/divide unit for the multicycle MIPS datapath.
// The control unit issues a MULT or DIV command. The unit iterates one bit
// per cycle. The 64-bit result is then committed into HI/LO, where MFHI and
// MFLO can read it. The control unit waits on busy/done. It branches to its
// divide-by-zero handler when div0 is raised.
//
// Ports:
//   clock    - system clock, all state changes on the rising edge
//   reset    - asynchronous, active-high; clears every register
//   mult_div - command: 00 none, 01 MULT, 10 DIV, 11 reserved (ignored)
//   a        - rs operand (multiplicand / dividend), signed
//   b        - rt operand (multiplier / divisor), signed
//   busy     - high while an operation is in flight (MULT, DIV, FIX)
//   done     - one-cycle pulse once a result is committed or div0 flagged
//   div0     - sticky divide-by-zero flag, cleared by the next command
//   hi, lo   - result registers (product high/low, remainder/quotient)
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mult_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [1:0] CMD_MULT = 2'b01;
  localparam logic [1:0] CMD_DIV  = 2'b10;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] counter;

  // Shared working registers.
  // MULT: acc is the Booth accumulator and quo holds the multiplier.
  //       q_m1 is the extra Booth bit.
  // DIV:  acc holds the partial remainder and quo the dividend/quotient.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] quo;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;
  logic             is_div;
  logic             neg_quo;
  logic             neg_rem;

  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  assign b_zero = (b == '0);

  // The magnitude of the most-negative operand is 2^(WIDTH-1).
  // That value still fits as an unsigned WIDTH-bit number.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // The accumulator is one bit wider than the operands.
  // This lets the most-negative multiplicand be added or subtracted without overflow.
  assign m_ext = {m_reg[WIDTH-1], m_reg};

  always_comb begin
    booth_sum = acc;
    case ({quo[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  // Restoring division step.
  // Bring the next dividend bit into the remainder.
  // Then subtract the divisor only when it fits.
  assign shifted = {acc[WIDTH-1:0], quo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, m_reg});
  assign diff    = shifted - {1'b0, m_reg};

  // Sign correction gives truncation toward zero.
  // The most-negative / -1 case wraps naturally: quotient magnitude 2^(WIDTH-1), no negation.
  assign rem_mag = acc[WIDTH-1:0];
  assign rem_fix = neg_rem ? -rem_mag : rem_mag;
  assign quo_fix = neg_quo ? -quo : quo;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (mult_div == CMD_MULT) begin
          next_state = MULT;
        end else if (mult_div == CMD_DIV) begin
          next_state = b_zero ? DONE : DIV;
        end
      end
      MULT: begin
        busy = 1'b1;
        if (counter == LAST_STEP) next_state = FIX;
      end
      DIV: begin
        busy = 1'b1;
        if (counter == LAST_STEP) next_state = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers.
  // hi/lo are written only in FIX.
  // An aborting reset therefore can never expose a partial result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter <= '0;
      acc     <= '0;
      quo     <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      is_div  <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_div == CMD_MULT) begin
            counter <= '0;
            acc     <= '0;
            quo     <= b;
            q_m1    <= 1'b0;
            m_reg   <= a;
            is_div  <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
          end else if (mult_div == CMD_DIV) begin
            counter <= '0;
            acc     <= '0;
            quo     <= a_mag;
            q_m1    <= 1'b0;
            m_reg   <= b_mag;
            is_div  <= 1'b1;
            neg_quo <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem <= a[WIDTH-1];
            div0    <= b_zero;
          end
        end
        MULT: begin
          // Arithmetic right shift of {acc, quo, q_m1} after the Booth add/sub.
          acc     <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          quo     <= {booth_sum[0], quo[WIDTH-1:1]};
          q_m1    <= quo[0];
          counter <= counter + 1'b1;
        end
        DIV: begin
          if (fits) begin
            acc <= diff;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            acc <= shifted;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          counter <= counter + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= acc[WIDTH-1:0];
            lo <= quo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
